// File: rtl/mcp_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, then a sign-fix cycle and a Done pulse.
// Define MCP_DIV_SIGNED_EN to add the Signed_Op port, signed result correction and OVF_F detection.
module mcp_divider #(
    parameter int WL = 32
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          Start,
`ifdef MCP_DIV_SIGNED_EN
    input  logic          Signed_Op,
`endif
    input  logic [WL-1:0] Dividend,
    input  logic [WL-1:0] Divisor,
    output logic          Busy,
    output logic          Done,
    output logic [WL-1:0] Quotient,
    output logic [WL-1:0] Remainder,
    output logic          DIVZ_F,
    output logic          OVF_F
);
    localparam int CW = $clog2(WL) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [WL-1:0] quo_reg;
    logic [WL-1:0] dsr_reg;
    logic [WL:0]   rem_reg;

    logic [WL-1:0] dvd_mag;
    logic [WL-1:0] dsr_mag;
    logic [WL-1:0] quo_fix;
    logic [WL-1:0] rem_fix;
    logic [WL:0]   rem_shift;
    logic [WL+1:0] diff;

`ifdef MCP_DIV_SIGNED_EN
    logic q_neg_reg;
    logic r_neg_reg;
    logic ovf_reg;
    logic q_neg;
    logic r_neg;
    logic ovf;

    // Operate on magnitudes; the remainder follows the dividend's sign (truncating division).
    always_comb begin
        q_neg   = Signed_Op & (Dividend[WL-1] ^ Divisor[WL-1]);
        r_neg   = Signed_Op & Dividend[WL-1];
        dvd_mag = r_neg ? -Dividend : Dividend;
        dsr_mag = (Signed_Op & Divisor[WL-1]) ? -Divisor : Divisor;
        ovf     = Signed_Op && (Dividend == {1'b1, {(WL-1){1'b0}}}) && (&Divisor);
        quo_fix = q_neg_reg ? -quo_reg : quo_reg;
        rem_fix = r_neg_reg ? -rem_reg[WL-1:0] : rem_reg[WL-1:0];
    end

    assign OVF_F = ovf_reg;
`else
    always_comb begin
        dvd_mag = Dividend;
        dsr_mag = Divisor;
        quo_fix = quo_reg;
        rem_fix = rem_reg[WL-1:0];
    end

    assign OVF_F = 1'b0;
`endif

    // Bring the next dividend bit into the partial remainder and trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem_reg[WL-1:0], quo_reg[WL-1]};
        diff      = {rem_reg, quo_reg[WL-1]} - {2'b00, dsr_reg};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg <= IDLE;
            count_reg <= '0;
            quo_reg   <= '0;
            dsr_reg   <= '0;
            rem_reg   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DIVZ_F    <= 1'b0;
`ifdef MCP_DIV_SIGNED_EN
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            ovf_reg   <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        Busy      <= 1'b1;
                        DIVZ_F    <= 1'b0;
                        quo_reg   <= dvd_mag;
                        dsr_reg   <= dsr_mag;
                        rem_reg   <= '0;
                        count_reg <= '0;
`ifdef MCP_DIV_SIGNED_EN
                        q_neg_reg <= q_neg;
                        r_neg_reg <= r_neg;
                        ovf_reg   <= ovf;
`endif
                        if (Divisor == '0) begin
                            DIVZ_F    <= 1'b1;
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            Done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[WL+1]) begin
                        rem_reg <= diff[WL:0];
                        quo_reg <= {quo_reg[WL-2:0], 1'b1};
                    end else begin
                        rem_reg <= rem_shift;
                        quo_reg <= {quo_reg[WL-2:0], 1'b0};
                    end
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == CW'(WL - 1))
                        state_reg <= FIX;
                end
                FIX: begin
                    Quotient  <= quo_fix;
                    Remainder <= rem_fix;
                    Done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    Busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcp_divider.sv
// Directed bench for mcp_divider: arithmetic reference model, per-cycle Busy/Done/result compare.
// Signed vectors run only when MCP_DIV_SIGNED_EN is defined.
module tb_mcp_divider;
    localparam int WL = 32;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          Start;
    logic          sgn_op;
    logic [WL-1:0] Dividend;
    logic [WL-1:0] Divisor;
    logic          Busy;
    logic          Done;
    logic [WL-1:0] Quotient;
    logic [WL-1:0] Remainder;
    logic          DIVZ_F;
    logic          OVF_F;

    always #5 CLK = ~CLK;

    mcp_divider #(.WL(WL)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Start    (Start),
`ifdef MCP_DIV_SIGNED_EN
        .Signed_Op(sgn_op),
`endif
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DIVZ_F   (DIVZ_F),
        .OVF_F    (OVF_F)
    );

    typedef struct packed {
        logic [WL-1:0] q;
        logic [WL-1:0] r;
        logic          dz;
        logic          ov;
    } res_t;

    typedef struct {
        int   start;
        int   due;
        res_t res;
    } exp_t;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t pend[$];
    res_t last = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic res_t model(input bit sgn, input logic [WL-1:0] a, input logic [WL-1:0] b);
        res_t   m;
        longint sa;
        longint sb;
        m = '0;
        if (b == '0) begin
            m.q  = '1;
            m.r  = a;
            m.dz = 1'b1;
        end else if (sgn) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            m.q  = WL'(sa / sb);
            m.r  = WL'(sa % sb);
            m.ov = (a == {1'b1, {(WL-1){1'b0}}}) && (b == '1);
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    task automatic chkw(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: Busy/Done every cycle, results on Done, held values while idle.
    always @(negedge CLK) begin
        bit eb;
        bit ed;
        eb = 1'b0;
        ed = 1'b0;
        if (pend.size() > 0) begin
            eb = (cyc > pend[0].start) && (cyc <= pend[0].due);
            ed = (cyc == pend[0].due);
        end
        chk1("busy", Busy, eb);
        chk1("done", Done, ed);
        if (ed) begin
            chkw("quotient", Quotient, pend[0].res.q);
            chkw("remainder", Remainder, pend[0].res.r);
            chk1("divz_f", DIVZ_F, pend[0].res.dz);
            chk1("ovf_f", OVF_F, pend[0].res.ov);
            $display("txn a/b done at cycle %0d: q=%h r=%h divz=%b ovf=%b", cyc, Quotient, Remainder, DIVZ_F, OVF_F);
            last = pend[0].res;
            void'(pend.pop_front());
        end else if (pend.size() == 0) begin
            chkw("hold_quotient", Quotient, last.q);
            chkw("hold_remainder", Remainder, last.r);
            chk1("hold_divz_f", DIVZ_F, last.dz);
            chk1("hold_ovf_f", OVF_F, last.ov);
        end
    end

    task automatic issue(input bit sgn, input logic [WL-1:0] a, input logic [WL-1:0] b);
        exp_t e;
        bit   eff;
`ifdef MCP_DIV_SIGNED_EN
        eff = sgn;
`else
        eff = 1'b0;
`endif
        @(negedge CLK);
        Start    = 1'b1;
        sgn_op   = sgn;
        Dividend = a;
        Divisor  = b;
        e.start  = cyc;
        e.due    = cyc + ((b == '0) ? 1 : WL + 2);
        e.res    = model(eff, a, b);
        pend.push_back(e);
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && pend.size() > 0; i++)
            @(negedge CLK);
        if (pend.size() > 0) begin
            chk1("done_timeout", 1'b0, 1'b1);
            pend.delete();
        end
        @(negedge CLK);
    endtask

    task automatic run(input bit sgn, input logic [WL-1:0] a, input logic [WL-1:0] b,
                       input logic [WL-1:0] eq, input logic [WL-1:0] er, input bit edz, input bit eov);
        issue(sgn, a, b);
        wait_idle();
        chkw("lit_quotient", Quotient, eq);
        chkw("lit_remainder", Remainder, er);
        chk1("lit_divz_f", DIVZ_F, edz);
        chk1("lit_ovf_f", OVF_F, eov);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        res_t m;
        RSTn     = 1'b1;
        Start    = 1'b0;
        sgn_op   = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #2 RSTn = 1'b0;
        #1;
        chk1("reset_busy", Busy, 1'b0);
        chk1("reset_done", Done, 1'b0);
        chkw("reset_quotient", Quotient, '0);
        chkw("reset_remainder", Remainder, '0);
        repeat (3) @(negedge CLK);
        #2 RSTn = 1'b1;

        // Pin the model against hand-worked results.
        m = model(1'b0, 32'd100, 32'd7);
        chkw("model_100_7_q", m.q, 32'd14);
        chkw("model_100_7_r", m.r, 32'd2);
        m = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        chkw("model_m7_2_q", m.q, 32'hFFFF_FFFD);
        chkw("model_m7_2_r", m.r, 32'hFFFF_FFFF);
        m = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chkw("model_ovf_q", m.q, 32'h8000_0000);
        chk1("model_ovf_f", m.ov, 1'b1);

        run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        run(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run(1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b0);
`ifdef MCP_DIV_SIGNED_EN
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b0);
`endif

        // A second Start mid-calculation must be ignored.
        issue(1'b0, 32'd1000, 32'd10);
        repeat (4) @(negedge CLK);
        Start    = 1'b1;
        Dividend = 32'd7;
        Divisor  = 32'd0;
        @(negedge CLK);
        Start = 1'b0;
        wait_idle();
        chkw("ignored_start_q", Quotient, 32'd100);
        chkw("ignored_start_r", Remainder, 32'd0);

        // Reset mid-calculation aborts the divide at once.
        issue(1'b0, 32'd50, 32'd3);
        repeat (9) @(negedge CLK);
        #2 RSTn = 1'b0;
        pend.delete();
        last = '0;
        #1;
        chk1("abort_busy", Busy, 1'b0);
        chk1("abort_done", Done, 1'b0);
        chkw("abort_quotient", Quotient, '0);
        chkw("abort_remainder", Remainder, '0);
        chk1("abort_divz_f", DIVZ_F, 1'b0);
        chk1("abort_ovf_f", OVF_F, 1'b0);
        repeat (2) @(negedge CLK);
        #2 RSTn = 1'b1;
        run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
